mips32_alu_arbiter: RTL

Shares a single `mips32_alu` instance between two requesters, such as an integer pipeline port and a multi-cycle helper like an address or branch unit. Each requester has a valid/ready request channel and a response channel. The block grants the ALU round-robin, registers the operands, evaluates one operation, and holds the registered result plus flags until the owning requester accepts it. It sits between the issue logic and the ALU, and contains the ALU instance.

---
 rtl/mips32_alu_arbiter_if.sv | 41 ++++
 rtl/mips32_alu_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips32_alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and mips32_alu_arbiter.
// master = requester side (testbench/issue logic), slave = arbiter.
interface mips32_alu_arbiter_if #(
  parameter int DATAWIDTH = 32
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [3:0]           req0_op;
  logic [DATAWIDTH-1:0] req0_a;
  logic [DATAWIDTH-1:0] req0_b;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [3:0]           req1_op;
  logic [DATAWIDTH-1:0] req1_a;
  logic [DATAWIDTH-1:0] req1_b;
  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic [DATAWIDTH-1:0] rsp_data;
  logic                 rsp_zero;
  logic                 rsp_less;
  logic                 rsp_ovf;
  logic                 busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_zero, rsp_less, rsp_ovf, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_data, rsp_zero, rsp_less, rsp_ovf, busy
  );
endinterface

// File: rtl/mips32_alu_arbiter.sv
// Round-robin sharing of one combinational mips32_alu between two requesters.
// Operands are registered on grant; result and flags are held until the owner accepts.

module mips32_alu #(
  parameter int DATAWIDTH = 32
) (
  input  logic [3:0]           ALU_op,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic [DATAWIDTH-1:0] ALU_out,
  output logic                 Zero,
  output logic                 Less,
  output logic                 Overflow_out
);
  localparam int SHW = $clog2(DATAWIDTH);
  localparam int MSB = DATAWIDTH - 1;

  logic [DATAWIDTH-1:0] sum;
  logic [DATAWIDTH-1:0] diff;
  logic                 lt_s;
  logic                 lt_u;

  assign sum  = A + B;
  assign diff = A - B;
  assign lt_s = $signed(A) < $signed(B);
  assign lt_u = A < B;

  always_comb begin
    ALU_out = '0;
    case (ALU_op)
      4'b0000: ALU_out = A & B;
      4'b0001: ALU_out = A | B;
      4'b0010: ALU_out = A ^ B;
      4'b0011: ALU_out = ~(A | B);
      4'b0100: ALU_out = sum;
      4'b0101: ALU_out = diff;
      4'b0110: ALU_out = {{(DATAWIDTH-1){1'b0}}, lt_s};
      4'b0111: ALU_out = {{(DATAWIDTH-1){1'b0}}, lt_u};
      4'b1000: ALU_out = A << B[SHW-1:0];
      4'b1001: ALU_out = A >> B[SHW-1:0];
      4'b1010: ALU_out = $unsigned($signed(A) >>> B[SHW-1:0]);
      4'b1011: ALU_out = B;
      4'b1110: ALU_out = sum;
      4'b1111: ALU_out = diff;
      default: ALU_out = '0;
    endcase
  end

  // Only the trapping add/sub encodings report signed overflow.
  always_comb begin
    Overflow_out = 1'b0;
    if (ALU_op == 4'b1110)
      Overflow_out = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
    else if (ALU_op == 4'b1111)
      Overflow_out = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
  end

  assign Less = (ALU_op == 4'b0111) ? lt_u : lt_s;
  assign Zero = (ALU_out == '0);
endmodule

module mips32_alu_arbiter #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mips32_alu_arbiter_if.slave  bus
);
  // state | meaning
  // IDLE  | no operation in flight, grant allowed
  // EXEC  | ALU evaluating the registered operands
  // HOLD  | result held for owner, grant allowed when owner accepts
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t               state;
  logic                 owner;
  logic                 last;
  logic [3:0]           op_q;
  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [DATAWIDTH-1:0] data_q;
  logic                 zero_q;
  logic                 less_q;
  logic                 ovf_q;
  logic                 rsp0_valid_q;
  logic                 rsp1_valid_q;
  logic                 busy_q;

  logic [DATAWIDTH-1:0] alu_out;
  logic                 alu_zero;
  logic                 alu_less;
  logic                 alu_ovf;

  logic owner_rdy;
  logic win;
  logic grant_ok;
  logic grant;

  mips32_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
    .ALU_op       (op_q),
    .A            (a_q),
    .B            (b_q),
    .ALU_out      (alu_out),
    .Zero         (alu_zero),
    .Less         (alu_less),
    .Overflow_out (alu_ovf)
  );

  // Contention goes to whoever was not granted last; a lone requester always wins.
  assign owner_rdy = owner ? bus.rsp1_ready : bus.rsp0_ready;
  assign win       = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
  assign grant_ok  = !rst && ((state == IDLE) || ((state == HOLD) && owner_rdy));
  assign grant     = grant_ok && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = grant_ok && bus.req0_valid && !win;
  assign bus.req1_ready = grant_ok && bus.req1_valid && win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      less_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_q   <= win ? bus.req1_op : bus.req0_op;
            a_q    <= win ? bus.req1_a  : bus.req0_a;
            b_q    <= win ? bus.req1_b  : bus.req0_b;
            owner  <= win;
            last   <= win;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          data_q       <= alu_out;
          zero_q       <= alu_zero;
          less_q       <= alu_less;
          ovf_q        <= alu_ovf;
          rsp0_valid_q <= !owner;
          rsp1_valid_q <= owner;
          state        <= HOLD;
        end
        HOLD: begin
          if (owner_rdy) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            if (grant) begin
              op_q  <= win ? bus.req1_op : bus.req0_op;
              a_q   <= win ? bus.req1_a  : bus.req0_a;
              b_q   <= win ? bus.req1_b  : bus.req0_b;
              owner <= win;
              last  <= win;
              state <= EXEC;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_less   = less_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.busy       = busy_q;
endmodule
